// File: rtl/wr_pack_pkg.sv
// rtl/wr_pack_pkg.sv - shared types and constants for the write line packer
package wr_pack_pkg;
  localparam int LINE_W         = 512;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int WIDX_W         = 4;

  typedef logic [WORDS_PER_LINE-1:0] mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_MERGE_PEND
  } state_e;

  // Reason the buffered line is being written out; picks the completion action.
  typedef enum logic [1:0] {
    PEND_FENCE,
    PEND_MISS,
    PEND_FLUSH
  } pend_e;
endpackage

// File: rtl/wr_line_buf.sv
// rtl/wr_line_buf.sv - one cache-line write-combining buffer with per-word valid mask
module wr_line_buf
  import wr_pack_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 merge_en_i,
  input  logic [WIDX_W-1:0]                    merge_idx_i,
  input  logic [DATA_WIDTH-1:0]                merge_word_i,
  input  logic                                 clear_i,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_o,
  output mask_t                                mask_o,
  output logic                                 full_o
);
  logic [DATA_WIDTH-1:0] word_q [WORDS_PER_LINE];
  mask_t                 mask_q;
  mask_t                 mask_d;

  always_comb begin
    mask_d = mask_q;
    if (clear_i) begin
      mask_d = '0;
    end else if (merge_en_i) begin
      mask_d[merge_idx_i] = 1'b1;
    end
  end

  // Full flag looks at the next mask so a completing merge is seen in the same cycle.
  assign full_o = &mask_d;
  assign mask_o = mask_q;

  always_comb begin
    line_o = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      line_o[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) word_q[i] <= '0;
    end else begin
      mask_q <= mask_d;
      if (clear_i) begin
        for (int i = 0; i < WORDS_PER_LINE; i++) word_q[i] <= '0;
      end else if (merge_en_i) begin
        word_q[merge_idx_i] <= merge_word_i;
      end
    end
  end
endmodule

// File: rtl/wr_line_packer.sv
// rtl/wr_line_packer.sv - merges 32-bit word writes into 512-bit CCI line writes; WR_PACKER_AUTOFLUSH_EN flushes full lines
module wr_line_packer
  import wr_pack_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = LINE_W,
  parameter int DATA_WIDTH  = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_LMT+3:0]    in_wr_addr,
  input  logic [MDATA-1:0]       in_wr_mdata,
  input  logic [DATA_WIDTH-1:0]  in_wr_data,
  input  logic                   in_wr_en,
  input  logic                   in_wr_now,
  output logic                   in_wr_almostfull,
  output logic                   in_wr_rsp_valid,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output mask_t                  wr_req_wmask,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp_valid
);
`ifdef WR_PACKER_AUTOFLUSH_EN
  localparam bit AUTOFLUSH_EN = 1'b1;
`else
  localparam bit AUTOFLUSH_EN = 1'b0;
`endif

  state_e                  state_q;
  pend_e                   kind_q;
  logic [ADDR_LMT-1:0]     line_q;
  logic [MDATA-1:0]        mdata_q;
  logic [DATA_WIDTH-1:0]   pend_word_q;
  logic [WIDX_W-1:0]       pend_idx_q;
  logic [ADDR_LMT-1:0]     pend_line_q;
  logic [MDATA-1:0]        pend_mdata_q;
  logic                    rsp_valid_q;
  logic                    req_en_q;
  logic [ADDR_LMT-1:0]     req_addr_q;
  logic [MDATA-1:0]        req_mdata_q;
  logic [CACHE_WIDTH-1:0]  req_data_q;
  mask_t                   req_mask_q;

  logic [ADDR_LMT-1:0]     in_line;
  logic                    accept, is_fence, hit, miss, start_issue, flush_hit;
  logic                    merge_en, clear, buf_full;
  logic [WIDX_W-1:0]       merge_idx;
  logic [DATA_WIDTH-1:0]   merge_word;
  logic [CACHE_WIDTH-1:0]  buf_line;
  mask_t                   buf_mask;

  assign in_line     = in_wr_addr[ADDR_LMT+3:4];
  assign accept      = in_wr_en && (state_q == ST_IDLE || state_q == ST_HOLD);
  assign is_fence    = accept && in_wr_now;
  assign hit         = accept && !in_wr_now && (state_q == ST_IDLE || in_line == line_q);
  assign miss        = accept && !in_wr_now && !hit;
  assign start_issue = miss || (is_fence && state_q == ST_HOLD);
  assign flush_hit   = AUTOFLUSH_EN && hit && buf_full;
  assign clear       = (state_q == ST_WAIT_RSP) && wr_rsp_valid;
  assign merge_en    = hit || (state_q == ST_MERGE_PEND);
  assign merge_idx   = (state_q == ST_MERGE_PEND) ? pend_idx_q  : in_wr_addr[WIDX_W-1:0];
  assign merge_word  = (state_q == ST_MERGE_PEND) ? pend_word_q : in_wr_data;

  wr_line_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .merge_en_i   (merge_en),
    .merge_idx_i  (merge_idx),
    .merge_word_i (merge_word),
    .clear_i      (clear),
    .line_o       (buf_line),
    .mask_o       (buf_mask),
    .full_o       (buf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= PEND_FENCE;
      line_q       <= '0;
      mdata_q      <= '0;
      pend_word_q  <= '0;
      pend_idx_q   <= '0;
      pend_line_q  <= '0;
      pend_mdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      req_en_q     <= 1'b0;
      req_addr_q   <= '0;
      req_mdata_q  <= '0;
      req_data_q   <= '0;
      req_mask_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      req_en_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (hit) begin
            line_q      <= in_line;
            mdata_q     <= in_wr_mdata;
            rsp_valid_q <= 1'b1;
            state_q     <= flush_hit ? ST_ISSUE : ST_HOLD;
            if (flush_hit) kind_q <= PEND_FLUSH;
          end else if (is_fence && state_q == ST_IDLE) begin
            rsp_valid_q <= 1'b1;
          end else if (is_fence) begin
            kind_q  <= PEND_FENCE;
            state_q <= ST_ISSUE;
          end else if (miss) begin
            pend_word_q  <= in_wr_data;
            pend_idx_q   <= in_wr_addr[WIDX_W-1:0];
            pend_line_q  <= in_line;
            pend_mdata_q <= in_wr_mdata;
            kind_q       <= PEND_MISS;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_ISSUE;
        ST_WAIT_RSP: begin
          if (wr_rsp_valid) begin
            case (kind_q)
              PEND_FENCE: begin
                rsp_valid_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
              PEND_MISS: state_q <= ST_MERGE_PEND;
              default:   state_q <= ST_IDLE;
            endcase
          end
        end
        ST_MERGE_PEND: begin
          line_q      <= pend_line_q;
          mdata_q     <= pend_mdata_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        default: state_q <= ST_IDLE;
      endcase
      // CCI almostfull is a look-ahead: a low sample lets the line go out on the next cycle.
      if ((start_issue || state_q == ST_ISSUE) && !wr_req_almostfull) begin
        req_en_q    <= 1'b1;
        req_addr_q  <= line_q;
        req_data_q  <= buf_line;
        req_mask_q  <= buf_mask;
        req_mdata_q <= mdata_q;
        state_q     <= ST_WAIT_RSP;
      end
    end
  end

  assign in_wr_almostfull = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP) ||
                            (state_q == ST_MERGE_PEND);
  assign in_wr_rsp_valid  = rsp_valid_q;
  assign wr_req_en        = req_en_q;
  assign wr_req_addr      = req_addr_q;
  assign wr_req_mdata     = req_mdata_q;
  assign wr_req_data      = req_data_q;
  assign wr_req_wmask     = req_mask_q;
endmodule
